cmp_iter_nb: RTL

- Parametrised, multi-cycle integer comparator for the jedro ALU/branch path.
- Generalises the signed/unsigned less-than blocks to all six RISC-V branch relations (EQ, NE, LT, GE, LTU, GEU).
- Scans CHUNK bits per cycle from the MSB and exits early on the first differing chunk, trading latency for area.
- Uses a valid/ready handshake on both sides so it can stall behind a slow consumer.

---
 rtl/cmp_iter_nb_pkg.sv | 30 +++
 rtl/cmp_iter_nb_if.sv | 24 ++
 rtl/cmp_iter_nb_chunk.sv | 12 +
 rtl/cmp_iter_nb.sv | 98 +++++++++
 4 files changed

// File: rtl/cmp_iter_nb_pkg.sv
// Shared constants for the iterative comparator: branch relation codes,
// FSM state encodings and the relation-to-flag mapping.
package cmp_iter_nb_pkg;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == CMP_LT) || (op == CMP_GE);
  endfunction

  // Unused funct3 codes (010/011) fall into the EQ default.
  function automatic logic rel_flag(input logic [2:0] op, input logic lt, input logic eq);
    case (op)
      CMP_NE:           return !eq;
      CMP_LT, CMP_LTU:  return lt;
      CMP_GE, CMP_GEU:  return !lt;
      default:          return eq;
    endcase
  endfunction

endpackage

// File: rtl/cmp_iter_nb_if.sv
// Request/response handshake bundle for cmp_iter_nb; names are from the
// comparator's point of view (slave modport).
interface cmp_iter_nb_if #(parameter int W = 32);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [2:0]   op_i;
  logic         abort_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         flag_o;
  logic [W-1:0] res_o;

  modport master (
    output in_valid_i, a_i, b_i, op_i, abort_i, out_ready_i,
    input  in_ready_o, out_valid_o, flag_o, res_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, op_i, abort_i, out_ready_i,
    output in_ready_o, out_valid_o, flag_o, res_o
  );
endinterface

// File: rtl/cmp_iter_nb_chunk.sv
// Unsigned less-than / equal for one CHUNK-bit slice.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);
  assign lt_o = a_i < b_i;
  assign eq_o = a_i == b_i;
endmodule

// File: rtl/cmp_iter_nb.sv
// Multi-cycle RISC-V branch-relation comparator: scans CHUNK bits per cycle
// from the MSB and stops at the first differing chunk.
module cmp_iter_nb
  import cmp_iter_nb_pkg::*;
#(
  parameter int W     = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  cmp_iter_nb_if.slave  bus
);

  localparam int NCHUNK = W / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [KW-1:0] k_q, k_d;
  logic          flag_q, flag_d;

  logic [CHUNK-1:0] ca, cb;
  logic             c_lt, c_eq;
  logic             sign_mm, lt_r, eq_r, finish;

  assign ca = a_q[int'(k_q)*CHUNK +: CHUNK];
  assign cb = b_q[int'(k_q)*CHUNK +: CHUNK];

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_i  (ca),
    .b_i  (cb),
    .lt_o (c_lt),
    .eq_o (c_eq)
  );

  // Differing sign bits decide a signed compare outright; with equal sign
  // bits the plain unsigned scan already gives the signed answer.
  assign sign_mm = is_signed_op(op_q) && (k_q == K_TOP) && (a_q[W-1] != b_q[W-1]);
  assign lt_r    = sign_mm ? a_q[W-1] : c_lt;
  assign eq_r    = !sign_mm && c_eq;
  assign finish  = sign_mm || !c_eq || (k_q == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    k_d     = k_q;
    flag_d  = flag_q;
    if (bus.abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          op_d    = bus.op_i;
          k_d     = K_TOP;
          state_d = ST_CMP;
        end
        ST_CMP: if (finish) begin
          flag_d  = rel_flag(op_q, lt_r, eq_r);
          state_d = ST_DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
        ST_DONE: if (bus.out_ready_i) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      k_q     <= K_TOP;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      k_q     <= k_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.in_ready_o  = state_q == ST_IDLE;
  assign bus.out_valid_o = state_q == ST_DONE;
  assign bus.flag_o      = flag_q;
  assign bus.res_o       = W'(flag_q);

endmodule
